pipeline_hazard_ctrl: RTL

//  Pipeline sequencer for the 5-stage core. Sits beside the EX-stage operand forwarding unit.

---
 rtl/pipeline_hazard_ctrl_if.sv | 40 ++++
 rtl/pipeline_hazard_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller:
// ID/EX/MEM hazard inputs and the PC / pipeline-register enables.
interface pipeline_hazard_ctrl_if;
  logic [5:0]  op_code_ID;
  logic [4:0]  rs_ID;
  logic [4:0]  rt_ID;
  logic        mem_read_EX;
  logic [4:0]  dest_EX;
  logic        branch_taken_EX;
  logic        dmem_req;
  logic        dmem_ready;
  logic        halt_req;

  logic        hold_pc;
  logic        hold_if_id;
  logic        hold_id_ex;
  logic        hold_ex_mem;
  logic        bubble_ex;
  logic        bubble_wb;
  logic        flush_if_id;
  logic        halt_ack;
  logic        mem_timeout;
  logic [15:0] stall_cnt;

  // Datapath side: presents hazard information, consumes enables.
  modport master (
    output op_code_ID, rs_ID, rt_ID, mem_read_EX, dest_EX, branch_taken_EX,
           dmem_req, dmem_ready, halt_req,
    input  hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, bubble_ex, bubble_wb,
           flush_if_id, halt_ack, mem_timeout, stall_cnt
  );

  // Controller side.
  modport slave (
    input  op_code_ID, rs_ID, rt_ID, mem_read_EX, dest_EX, branch_taken_EX,
           dmem_req, dmem_ready, halt_req,
    output hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, bubble_ex, bubble_wb,
           flush_if_id, halt_ack, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, taken-branch flushes,
// data-memory wait freezes and the halt/drain handshake, plus a stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter logic [5:0]  OP_LW     = 6'h23,
  parameter logic [5:0]  OP_BEQ    = 6'h04,
  parameter logic [5:0]  OP_ADD    = 6'h00,
  parameter logic [5:0]  OP_SUB    = 6'h00,
  parameter logic [5:0]  OP_SW     = 6'h2B,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned MAX_WAIT  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int unsigned STALL_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 ret_drain_q, ret_drain_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 timeout_q, timeout_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic uses_rt;
  logic raw_hit;
  logic live;
  logic freeze;
  logic branch;
  logic load_use;
  logic drain_mode;

  logic hold_pc_c;
  logic hold_if_id_c;
  logic hold_id_ex_c;
  logic hold_ex_mem_c;
  logic bubble_ex_c;
  logic bubble_wb_c;
  logic flush_if_id_c;
  logic halt_ack_c;
  logic mem_timeout_c;

  // RAW dependency of the ID instruction on a load sitting in EX; loads only read rs.
  always_comb begin
    uses_rt = ((hz.op_code_ID == OP_ADD) || (hz.op_code_ID == OP_SUB) ||
               (hz.op_code_ID == OP_SW)  || (hz.op_code_ID == OP_BEQ)) &&
              (hz.op_code_ID != OP_LW);
    raw_hit = hz.mem_read_EX && (hz.dest_EX != 5'd0) &&
              ((hz.dest_EX == hz.rs_ID) || (uses_rt && (hz.dest_EX == hz.rt_ID)));
  end

  // Hazard classification, enables and next-state.
  always_comb begin
    state_d       = state_q;
    ret_drain_d   = ret_drain_q;
    wait_cnt_d    = wait_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    timeout_d     = timeout_q;
    stall_cnt_d   = stall_cnt_q;
    hold_pc_c     = 1'b0;
    hold_if_id_c  = 1'b0;
    hold_id_ex_c  = 1'b0;
    hold_ex_mem_c = 1'b0;
    bubble_ex_c   = 1'b0;
    bubble_wb_c   = 1'b0;
    flush_if_id_c = 1'b0;
    halt_ack_c    = 1'b0;

    // Enables are forced low while reset is held, even with a memory wait pending.
    live       = rst_n && (state_q != HALTED);
    freeze     = live && hz.dmem_req && !hz.dmem_ready;
    branch     = live && !freeze && hz.branch_taken_EX;
    load_use   = live && !freeze && !branch && raw_hit;
    // The release cycle of a wait behaves like the state the wait interrupted.
    drain_mode = (state_q == DRAIN) || ((state_q == MEM_WAIT) && ret_drain_q);

    if (rst_n && (state_q == HALTED)) begin
      halt_ack_c    = 1'b1;
      hold_pc_c     = 1'b1;
      flush_if_id_c = 1'b1;
    end else if (freeze) begin
      hold_pc_c     = 1'b1;
      hold_if_id_c  = 1'b1;
      hold_id_ex_c  = 1'b1;
      hold_ex_mem_c = 1'b1;
      bubble_wb_c   = 1'b1;
    end else if (branch) begin
      flush_if_id_c = 1'b1;
      bubble_ex_c   = 1'b1;
    end else if (load_use) begin
      hold_pc_c     = 1'b1;
      hold_if_id_c  = 1'b1;
      bubble_ex_c   = 1'b1;
    end else if (rst_n && drain_mode) begin
      hold_pc_c     = 1'b1;
      flush_if_id_c = 1'b1;
    end

    mem_timeout_c = timeout_q ||
                    (freeze && (wait_cnt_q >= WAIT_W'(MAX_WAIT - 1)));
    timeout_d     = mem_timeout_c;

    if (freeze && (wait_cnt_q < WAIT_W'(MAX_WAIT))) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    if (hold_pc_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end

    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d     = MEM_WAIT;
          ret_drain_d = 1'b0;
        end else if (hz.halt_req) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (freeze) begin
          state_d     = MEM_WAIT;
          ret_drain_d = 1'b1;
        end else if (drain_cnt_q == DRAIN_W'(DRAIN_CYC - 1)) begin
          state_d     = HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!freeze) begin
          state_d    = ret_drain_q ? DRAIN : RUN;
          wait_cnt_d = '0;
        end
      end
      HALTED: begin
        if (!hz.halt_req) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ret_drain_q <= 1'b0;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_drain_q <= ret_drain_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.hold_pc     = hold_pc_c;
  assign hz.hold_if_id  = hold_if_id_c;
  assign hz.hold_id_ex  = hold_id_ex_c;
  assign hz.hold_ex_mem = hold_ex_mem_c;
  assign hz.bubble_ex   = bubble_ex_c;
  assign hz.bubble_wb   = bubble_wb_c;
  assign hz.flush_if_id = flush_if_id_c;
  assign hz.halt_ack    = halt_ack_c;
  assign hz.mem_timeout = mem_timeout_c;
  assign hz.stall_cnt   = stall_cnt_q;

endmodule
